ram_stream_reader: RTL

//  Reads a block of words out of the lab RAM and streams them on a valid/ready port.

---
 rtl/cod_pkg.sv | 20 ++
 rtl/ram_rd_fifo.sv | 56 +++++
 rtl/ram_stream_reader.sv | 121 ++++++++++++
 3 files changed

// File: rtl/cod_pkg.sv
// Shared types for the RAM stream reader: controller state encoding and read-FIFO geometry.
package cod_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam int FIFO_DEPTH = 2;
   localparam int FIFO_PTR_W = 1;
   localparam int FIFO_CNT_W = 2;

   // Circular pointer advance; wraps after the last FIFO slot.
   function automatic logic [FIFO_PTR_W-1:0] ptr_next(input logic [FIFO_PTR_W-1:0] p);
      return (p == FIFO_PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_PTR_W'(1);
   endfunction

endpackage

// File: rtl/ram_rd_fifo.sv
// Small synchronous FIFO holding read-back words with their address and last flag.
// Push and pop may happen in the same cycle, including when full.
module ram_rd_fifo
   import cod_pkg::*;
#(
   parameter int W = 39
)
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic [W-1:0]          wdata,
   input  logic                  pop,
   output logic [W-1:0]          rdata,
   output logic [FIFO_CNT_W-1:0] count
);

   logic [W-1:0]          mem [FIFO_DEPTH];
   logic [FIFO_PTR_W-1:0] wr_ptr;
   logic [FIFO_PTR_W-1:0] rd_ptr;
   logic                  empty;
   logic                  full;
   logic                  do_push;
   logic                  do_pop;

   assign empty   = (count == '0);
   assign full    = (count == FIFO_CNT_W'(FIFO_DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= ptr_next(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + FIFO_CNT_W'(1);
            2'b01:   count <= count - FIFO_CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ram_stream_reader.sv
// Streams a block of RAM words onto a valid/ready port, issuing reads only when the
// small output FIFO is guaranteed to have room for the returning data.
module ram_stream_reader
   import cod_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 7
)
(
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic              ram_re,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_addr,
   output logic              out_last
);

   localparam int FW = DATA_W + ADDR_W + 1;

   state_t                  state;
   logic [CNT_W-1:0]        issue_left;
   logic                    inflight;
   logic [ADDR_W-1:0]       inflight_addr;
   logic                    inflight_last;
   logic [FIFO_CNT_W-1:0]   fifo_cnt;
   logic [FW-1:0]           fifo_head;
   logic                    pop;
   logic [2:0]              occupancy;

   // Valid/ready: a word moves when out_valid && out_ready on a rising edge; the head
   // of the FIFO is presented unchanged until that happens.
   assign out_valid = (fifo_cnt != '0);
   assign pop       = out_valid && out_ready;
   assign out_last  = fifo_head[FW-1];
   assign out_addr  = fifo_head[FW-2 -: ADDR_W];
   assign out_data  = fifo_head[DATA_W-1:0];

   // Slots committed after this edge: stored words plus the read in flight, minus the
   // word leaving now. A new read is only issued when one slot is still free.
   assign occupancy = 3'(fifo_cnt) + 3'(inflight) - 3'(pop);
   assign ram_re    = (state == READ) && (occupancy < 3'(FIFO_DEPTH));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         ram_addr      <= '0;
         issue_left    <= '0;
         inflight      <= 1'b0;
         inflight_addr <= '0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= ram_re;
         inflight_addr <= ram_addr;
         inflight_last <= ram_re && (issue_left == CNT_W'(1));
         done          <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  ram_addr   <= base_addr;
                  issue_left <= count;
                  if (count == '0) begin
                     state <= FIN;
                     done  <= 1'b1;
                  end else begin
                     state <= READ;
                     busy  <= 1'b1;
                  end
               end
            end
            READ: begin
               if (ram_re) begin
                  ram_addr   <= ram_addr + ADDR_W'(1);
                  issue_left <= issue_left - CNT_W'(1);
                  if (issue_left == CNT_W'(1)) begin
                     state <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (pop && out_last) begin
                  state <= FIN;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   ram_rd_fifo #(
      .W (FW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (inflight),
      .wdata ({inflight_last, inflight_addr, ram_rdata}),
      .pop   (pop),
      .rdata (fifo_head),
      .count (fifo_cnt)
   );

endmodule
